// File: rtl/mc_ctrl.sv
// mc_ctrl - multicycle control FSM for the single-datapath MIPS core.
//
// Sequences fetch, register file, ALU and data memory one instruction at a
// time. opcode/funct come from the instruction register, which is loaded only
// in S_IF, so they are stable from S_ID until the next fetch.
//
// Ports:
//   clk, Reset        rising-edge clock, asynchronous active-high reset
//   opcode, funct     IR[31:26], IR[5:0]
//   zero              ALU equal flag (meaningful in S_EX)
//   pc_wr, ir_wr      PC / IR write enables
//   npc_op            next-PC source: 00 PC+4, 01 beq, 10 jal, 11 jr
//   rf_wr             register file write enable
//   rf_a3_sel         dest reg: 00 rt, 01 rd, 10 $31
//   rf_wd_sel         write-back data: 00 ALU, 01 DM, 10 PC+4
//   alu_src           ALU B: 0 rt data, 1 extended immediate
//   alu_op            000 add, 001 sub, 010 or, 011 lui
//   ext_op            00 zero-extend, 01 sign-extend
//   dm_wr             data memory write enable
//   state             current FSM state (debug)
//   illegal           one-cycle pulse in S_ID on an unsupported encoding
//   cycle_cnt,
//   instr_cnt         performance counters, only with MC_CTRL_PERF_EN defined
//
// Optional feature macro: MC_CTRL_PERF_EN.
// PC_RESET is the reset value of the PC register elsewhere; no logic here.
module mc_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic [1:0]  npc_op,
    output logic        rf_wr,
    output logic [1:0]  rf_a3_sel,
    output logic [1:0]  rf_wd_sel,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic        dm_wr,
    output logic [2:0]  state,
    output logic        illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t cur, nxt;

    logic unused_pc_reset;
    assign unused_pc_reset = ^PC_RESET;

    // Instruction decode
    logic is_r, is_addu, is_subu, is_sll, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
    logic is_alu_r, legal;

    assign is_r     = (opcode == 6'h00);
    assign is_addu  = is_r && (funct == 6'h21);
    assign is_subu  = is_r && (funct == 6'h23);
    assign is_sll   = is_r && (funct == 6'h00);
    assign is_jr    = is_r && (funct == 6'h08);
    assign is_ori   = (opcode == 6'h0D);
    assign is_lui   = (opcode == 6'h0F);
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_beq   = (opcode == 6'h04);
    assign is_jal   = (opcode == 6'h03);
    assign is_alu_r = is_addu || is_subu || is_sll;
    assign legal    = is_alu_r || is_jr || is_ori || is_lui || is_lw ||
                      is_sw || is_beq || is_jal;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) cur <= S_IF;
        else       cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt       = S_IF;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        npc_op    = 2'b00;
        rf_wr     = 1'b0;
        rf_a3_sel = 2'b00;
        rf_wd_sel = 2'b00;
        alu_src   = 1'b0;
        alu_op    = 3'b000;
        ext_op    = 2'b00;
        dm_wr     = 1'b0;
        illegal   = 1'b0;

        // ALU/extension settings stay constant from S_EX through S_WB so the
        // ALU result register input does not change under the instruction.
        if (cur == S_EX || cur == S_MEM || cur == S_WB) begin
            if (is_subu || is_beq) alu_op = 3'b001;
            else if (is_ori)       alu_op = 3'b010;
            else if (is_lui)       alu_op = 3'b011;
            alu_src = is_ori || is_lui || is_lw || is_sw;
            if (is_lw || is_sw)    ext_op = 2'b01;
        end

        case (cur)
            S_IF: begin
                pc_wr = 1'b1;
                ir_wr = 1'b1;
                nxt   = S_ID;
            end
            S_ID: begin
                if (!legal) begin
                    illegal = 1'b1;
                    nxt     = S_IF;
                end else if (is_jal) begin
                    nxt = S_WB;
                end else begin
                    nxt = S_EX;
                end
            end
            S_EX: begin
                if (is_lw || is_sw) begin
                    nxt = S_MEM;
                end else if (is_beq) begin
                    // Not taken: PC already holds PC+4 from S_IF.
                    pc_wr  = zero;
                    npc_op = 2'b01;
                    nxt    = S_IF;
                end else if (is_jr) begin
                    pc_wr  = 1'b1;
                    npc_op = 2'b11;
                    nxt    = S_IF;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    dm_wr = 1'b1;
                    nxt   = S_IF;
                end else begin
                    nxt = S_WB;
                end
            end
            S_WB: begin
                rf_wr = 1'b1;
                nxt   = S_IF;
                if (is_jal) begin
                    rf_a3_sel = 2'b10;
                    rf_wd_sel = 2'b10;
                    pc_wr     = 1'b1;
                    npc_op    = 2'b10;
                end else if (is_lw) begin
                    rf_wd_sel = 2'b01;
                end else if (is_alu_r) begin
                    rf_a3_sel = 2'b01;
                end
            end
            default: nxt = S_IF;
        endcase

        // Reset gates every output combinationally so no strobe survives the
        // reset edge, even before the state register has been cleared.
        if (Reset) begin
            pc_wr     = 1'b0;
            ir_wr     = 1'b0;
            npc_op    = 2'b00;
            rf_wr     = 1'b0;
            rf_a3_sel = 2'b00;
            rf_wd_sel = 2'b00;
            alu_src   = 1'b0;
            alu_op    = 3'b000;
            ext_op    = 2'b00;
            dm_wr     = 1'b0;
            illegal   = 1'b0;
        end
    end

`ifdef MC_CTRL_PERF_EN
    // A legal instruction completes on any return to S_IF except from S_ID,
    // which only happens for an illegal encoding.
    logic instr_done;
    assign instr_done = (nxt == S_IF) && (cur != S_IF) && (cur != S_ID);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        pc_wr, ir_wr, rf_wr, alu_src, dm_wr, illegal;
    logic [1:0]  npc_op, rf_a3_sel, rf_wd_sel, ext_op;
    logic [2:0]  alu_op, state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_op(npc_op), .rf_wr(rf_wr),
        .rf_a3_sel(rf_a3_sel), .rf_wd_sel(rf_wd_sel), .alu_src(alu_src),
        .alu_op(alu_op), .ext_op(ext_op), .dm_wr(dm_wr), .state(state),
        .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    // Packed view: {state, pc_wr, ir_wr, npc_op, rf_wr, a3, wd, alu_src, alu_op, ext_op, dm_wr, illegal}
    logic [19:0] act;
    assign act = {state, pc_wr, ir_wr, npc_op, rf_wr, rf_a3_sel, rf_wd_sel,
                  alu_src, alu_op, ext_op, dm_wr, illegal};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Instruction classes
    localparam int C_ILL = 0, C_ADDU = 1, C_SUBU = 2, C_ORI = 3, C_LUI = 4,
                   C_LW = 5, C_SW = 6, C_BEQ = 7, C_JAL = 8, C_JR = 9;

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h21 || fn == 6'h00) return C_ADDU;  // nop behaves as addu-like R-type
                if (fn == 6'h23) return C_SUBU;
                if (fn == 6'h08) return C_JR;
                return C_ILL;
            end
            6'h0D: return C_ORI;
            6'h0F: return C_LUI;
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h04: return C_BEQ;
            6'h03: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // Cycle count per instruction class.
    function automatic int ncycles(input int c);
        case (c)
            C_ILL:               return 2;
            C_BEQ, C_JR, C_JAL:  return 3;
            C_LW:                return 5;
            default:             return 4;
        endcase
    endfunction

    // State visited in cycle k of an instruction of class c.
    function automatic logic [2:0] state_at(input int c, input int k);
        if (k < 2)        return 3'(k);
        if (c == C_JAL)   return 3'd4;
        if (k == 2)       return 3'd2;
        if (k == 3)       return (c == C_LW || c == C_SW) ? 3'd3 : 3'd4;
        return 3'd4;
    endfunction

    function automatic logic [19:0] expect_rec(input int c, input logic z, input int k);
        logic [2:0] st;
        logic pw, iw, rw, src, dw, il;
        logic [1:0] npc, a3, wd, ext;
        logic [2:0] aop;
        st = state_at(c, k);
        pw = 0; iw = 0; rw = 0; src = 0; dw = 0; il = 0;
        npc = 0; a3 = 0; wd = 0; ext = 0; aop = 0;
        if (st >= 3'd2 && c != C_JAL) begin
            case (c)
                C_SUBU, C_BEQ: aop = 3'b001;
                C_ORI: begin aop = 3'b010; src = 1; end
                C_LUI: begin aop = 3'b011; src = 1; end
                C_LW, C_SW: begin src = 1; ext = 2'b01; end
                default: ;
            endcase
        end
        case (st)
            3'd0: begin pw = 1; iw = 1; end
            3'd1: il = (c == C_ILL);
            3'd2: begin
                if (c == C_BEQ) begin pw = z; npc = 2'b01; end
                if (c == C_JR)  begin pw = 1; npc = 2'b11; end
            end
            3'd3: dw = (c == C_SW);
            default: begin
                rw = 1;
                case (c)
                    C_ADDU, C_SUBU: a3 = 2'b01;
                    C_LW:  wd = 2'b01;
                    C_JAL: begin a3 = 2'b10; wd = 2'b10; pw = 1; npc = 2'b10; end
                    default: ;
                endcase
            end
        endcase
        return {st, pw, iw, npc, rw, a3, wd, src, aop, ext, dw, il};
    endfunction

    // ---------------- compare process ----------------
    logic [19:0] expq[$];
    always @(negedge clk) begin
        if (expq.size() > 0) chk("cycle", 32'(act), 32'(expq.pop_front()));
    end

`ifdef MC_CTRL_PERF_EN
    int exp_instr = 0, exp_cyc = 0;
`endif

    // Issue one instruction starting in S_IF (called at posedge+1).
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int c, n;
        c = classify(op, fn);
        n = ncycles(c);
        opcode = op; funct = fn; zero = z;
`ifdef MC_CTRL_PERF_EN
        chk("instr_cnt", instr_cnt, 32'(exp_instr));
        chk("cycle_cnt", cycle_cnt, 32'(exp_cyc));
`endif
        for (int k = 0; k < n; k++) expq.push_back(expect_rec(c, z, k));
        repeat (n) @(posedge clk);
        #1;
`ifdef MC_CTRL_PERF_EN
        exp_cyc += n;
        if (c != C_ILL) exp_instr++;
`endif
    endtask

    initial begin
        Reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;

        // Model pins (hand-computed)
        chk("pin_jal_wb",  32'(expect_rec(C_JAL, 1'b0, 2)), 32'h95A00);
        chk("pin_sw_mem",  32'(expect_rec(C_SW, 1'b0, 3)),  32'h60086);
        chk("pin_addu_wb", 32'(expect_rec(C_ADDU, 1'b0, 3)), 32'h81400);
        chk("pin_lw_len",  32'(ncycles(classify(6'h23, 6'h00))), 32'd5);
        chk("pin_ill_fn",  32'(classify(6'h00, 6'h2A)), 32'(C_ILL));

        // Reset held for two cycles: everything reads 0.
        @(negedge clk); chk("reset_outs_1", 32'(act), 32'h0);
        @(negedge clk); chk("reset_outs_2", 32'(act), 32'h0);
        @(posedge clk); #1 Reset = 1'b0;

        run(6'h00, 6'h21, 1'b0);  // addu
        run(6'h00, 6'h23, 1'b0);  // subu
        run(6'h00, 6'h00, 1'b0);  // nop
        run(6'h0D, 6'h3F, 1'b0);  // ori
        run(6'h0F, 6'h00, 1'b1);  // lui
        run(6'h23, 6'h00, 1'b0);  // lw
        run(6'h2B, 6'h00, 1'b0);  // sw
        run(6'h04, 6'h00, 1'b1);  // beq taken
        run(6'h04, 6'h00, 1'b0);  // beq not taken
        run(6'h03, 6'h08, 1'b0);  // jal
        run(6'h00, 6'h08, 1'b1);  // jr
        run(6'h3F, 6'h21, 1'b0);  // illegal opcode
        run(6'h00, 6'h2A, 1'b0);  // illegal funct
        run(6'h00, 6'h21, 1'b0);  // addu after illegals

        // Reset asserted in S_MEM of sw.
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("sw_mem_dm_wr", 32'(dm_wr), 32'd1);
        chk("sw_mem_state", 32'(state), 32'd3);
        Reset = 1'b1;
        #1 chk("midreset_outs", 32'(act), 32'h0);
        @(posedge clk); #1 Reset = 1'b0;
`ifdef MC_CTRL_PERF_EN
        exp_instr = 0; exp_cyc = 0;
`endif
        run(6'h23, 6'h00, 1'b0);  // lw after reset
        run(6'h00, 6'h21, 1'b0);  // addu
`ifdef MC_CTRL_PERF_EN
        chk("instr_cnt_end", instr_cnt, 32'(exp_instr));
`endif
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
